// File: rtl/scalu_rs.sv
// Reservation station feeding the single-cycle scalar ALU: buffers dispatched ops,
// snoops the writeback bus for missing operands, issues one ready op per cycle.
// Optional oldest-first select is enabled by defining SCALU_RS_AGE_EN.
module scalu_rs #(
    parameter int DEPTH = 4,
    parameter int IDXW  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_valid,
    input  logic [4:0]  disp_op,
    input  logic [6:0]  disp_robid,
    input  logic [5:0]  disp_rd,
    input  logic        disp_op1_rdy,
    input  logic [31:0] disp_op1,
    input  logic        disp_op2_rdy,
    input  logic [31:0] disp_op2,
    output logic        rs_full,
    input  logic        wb_valid,
    input  logic [6:0]  wb_robid,
    input  logic [31:0] wb_result,
    output logic        exers_scalu_issue,
    output logic [4:0]  exers_scalu_op,
    output logic [6:0]  exers_robid,
    output logic [5:0]  exers_rd,
    output logic [31:0] exers_op1,
    output logic [31:0] exers_op2,
    input  logic        scalu_stall,
    input  logic        rob_flush
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] r1_q;
    logic [DEPTH-1:0] r2_q;
    logic [4:0]       op_q    [DEPTH];
    logic [6:0]       robid_q [DEPTH];
    logic [5:0]       rd_q    [DEPTH];
    logic [31:0]      op1_q   [DEPTH];
    logic [31:0]      op2_q   [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [IDXW-1:0]  alloc_idx;
    logic             alloc_found;
    logic             alloc_en;
    logic [IDXW-1:0]  sel_idx;
    logic             sel_found;
    logic             fire;
    logic             cap1;
    logic             cap2;

    assign ready    = valid_q & r1_q & r2_q;
    assign rs_full  = &valid_q;
    assign alloc_en = disp_valid & ~rs_full;

    // Operand arriving on the broadcast in the dispatch cycle is captured directly.
    assign cap1 = ~disp_op1_rdy & wb_valid & (disp_op1[6:0] == wb_robid);
    assign cap2 = ~disp_op2_rdy & wb_valid & (disp_op2[6:0] == wb_robid);

    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_idx   = IDXW'(i);
                alloc_found = 1'b1;
            end
        end
    end

`ifdef SCALU_RS_AGE_EN
    // age_q[i][j] set means entry i was allocated before entry j.
    logic [DEPTH-1:0] age_q [DEPTH];
    logic             older;

    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        older     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !sel_found) begin
                older = 1'b0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (ready[j] && age_q[j][i]) begin
                        older = 1'b1;
                    end
                end
                if (!older) begin
                    sel_idx   = IDXW'(i);
                    sel_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else if (alloc_en && !rob_flush) begin
            for (int j = 0; j < DEPTH; j++) begin
                age_q[alloc_idx][j] <= 1'b0;
                age_q[j][alloc_idx] <= (IDXW'(j) != alloc_idx);
            end
        end
    end
`else
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !sel_found) begin
                sel_idx   = IDXW'(i);
                sel_found = 1'b1;
            end
        end
    end
`endif

    assign exers_scalu_issue = |ready;
    assign fire              = exers_scalu_issue & ~scalu_stall;

    assign exers_scalu_op = exers_scalu_issue ? op_q[sel_idx]    : '0;
    assign exers_robid    = exers_scalu_issue ? robid_q[sel_idx] : '0;
    assign exers_rd       = exers_scalu_issue ? rd_q[sel_idx]    : '0;
    assign exers_op1      = exers_scalu_issue ? op1_q[sel_idx]   : '0;
    assign exers_op2      = exers_scalu_issue ? op2_q[sel_idx]   : '0;

    always_ff @(posedge clk) begin
        if (rst || rob_flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && wb_valid) begin
                    if (!r1_q[i] && (op1_q[i][6:0] == wb_robid)) begin
                        op1_q[i] <= wb_result;
                        r1_q[i]  <= 1'b1;
                    end
                    if (!r2_q[i] && (op2_q[i][6:0] == wb_robid)) begin
                        op2_q[i] <= wb_result;
                        r2_q[i]  <= 1'b1;
                    end
                end
            end
            if (fire) begin
                valid_q[sel_idx] <= 1'b0;
            end
            // Alloc target is always an invalid entry, so it never collides with the freed one.
            if (alloc_en) begin
                valid_q[alloc_idx] <= 1'b1;
                op_q[alloc_idx]    <= disp_op;
                robid_q[alloc_idx] <= disp_robid;
                rd_q[alloc_idx]    <= disp_rd;
                r1_q[alloc_idx]    <= disp_op1_rdy | cap1;
                r2_q[alloc_idx]    <= disp_op2_rdy | cap2;
                op1_q[alloc_idx]   <= cap1 ? wb_result : disp_op1;
                op2_q[alloc_idx]   <= cap2 ? wb_result : disp_op2;
            end
        end
    end

endmodule

// File: tb/tb_scalu_rs.sv
// Directed self-checking bench for scalu_rs (DEPTH=4); the ordering check follows
// SCALU_RS_AGE_EN so the same bench covers both builds.
module tb_scalu_rs;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_valid;
    logic [4:0]  disp_op;
    logic [6:0]  disp_robid;
    logic [5:0]  disp_rd;
    logic        disp_op1_rdy;
    logic [31:0] disp_op1;
    logic        disp_op2_rdy;
    logic [31:0] disp_op2;
    logic        rs_full;
    logic        wb_valid;
    logic [6:0]  wb_robid;
    logic [31:0] wb_result;
    logic        exers_scalu_issue;
    logic [4:0]  exers_scalu_op;
    logic [6:0]  exers_robid;
    logic [5:0]  exers_rd;
    logic [31:0] exers_op1;
    logic [31:0] exers_op2;
    logic        scalu_stall;
    logic        rob_flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scalu_rs #(.DEPTH(4), .IDXW(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .disp_valid        (disp_valid),
        .disp_op           (disp_op),
        .disp_robid        (disp_robid),
        .disp_rd           (disp_rd),
        .disp_op1_rdy      (disp_op1_rdy),
        .disp_op1          (disp_op1),
        .disp_op2_rdy      (disp_op2_rdy),
        .disp_op2          (disp_op2),
        .rs_full           (rs_full),
        .wb_valid          (wb_valid),
        .wb_robid          (wb_robid),
        .wb_result         (wb_result),
        .exers_scalu_issue (exers_scalu_issue),
        .exers_scalu_op    (exers_scalu_op),
        .exers_robid       (exers_robid),
        .exers_rd          (exers_rd),
        .exers_op1         (exers_op1),
        .exers_op2         (exers_op2),
        .scalu_stall       (scalu_stall),
        .rob_flush         (rob_flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [4:0] op, input logic [6:0] robid, input logic [5:0] rd,
                        input logic r1, input logic [31:0] o1,
                        input logic r2, input logic [31:0] o2);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_robid   = robid;
        disp_rd      = rd;
        disp_op1_rdy = r1;
        disp_op1     = o1;
        disp_op2_rdy = r2;
        disp_op2     = o2;
    endtask

    initial begin
        rst = 1'b1;
        disp_valid = 1'b0; disp_op = '0; disp_robid = '0; disp_rd = '0;
        disp_op1_rdy = 1'b0; disp_op1 = '0; disp_op2_rdy = 1'b0; disp_op2 = '0;
        wb_valid = 1'b0; wb_robid = '0; wb_result = '0;
        scalu_stall = 1'b0; rob_flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_issue", 32'(exers_scalu_issue), 32'd0);
        check("reset_full", 32'(rs_full), 32'd0);

        // Ready dispatch issues next cycle and frees.
        disp(5'h02, 7'h10, 6'd3, 1'b1, 32'd7, 1'b1, 32'd9);
        tick();
        disp_valid = 1'b0;
        check("rdy_issue", 32'(exers_scalu_issue), 32'd1);
        check("rdy_op", 32'(exers_scalu_op), 32'h02);
        check("rdy_robid", 32'(exers_robid), 32'h10);
        check("rdy_rd", 32'(exers_rd), 32'd3);
        check("rdy_op1", exers_op1, 32'd7);
        check("rdy_op2", exers_op2, 32'd9);
        tick();
        check("rdy_freed", 32'(exers_scalu_issue), 32'd0);

        // Wakeup from broadcast.
        disp(5'h03, 7'h11, 6'd4, 1'b0, 32'h10, 1'b1, 32'd1);
        tick();
        disp_valid = 1'b0;
        check("wk_wait0", 32'(exers_scalu_issue), 32'd0);
        tick();
        check("wk_wait1", 32'(exers_scalu_issue), 32'd0);
        wb_valid = 1'b1; wb_robid = 7'h10; wb_result = 32'hDEAD_BEEF;
        tick();
        wb_valid = 1'b0;
        check("wk_issue", 32'(exers_scalu_issue), 32'd1);
        check("wk_robid", 32'(exers_robid), 32'h11);
        check("wk_op1", exers_op1, 32'hDEAD_BEEF);
        check("wk_op2", exers_op2, 32'd1);
        tick();
        check("wk_freed", 32'(exers_scalu_issue), 32'd0);

        // Same-cycle capture on dispatch.
        disp(5'h04, 7'h21, 6'd5, 1'b1, 32'd3, 1'b0, 32'h20);
        wb_valid = 1'b1; wb_robid = 7'h20; wb_result = 32'h55;
        tick();
        disp_valid = 1'b0; wb_valid = 1'b0;
        check("cap_issue", 32'(exers_scalu_issue), 32'd1);
        check("cap_op2", exers_op2, 32'h55);
        check("cap_op1", exers_op1, 32'd3);
        tick();
        check("cap_freed", 32'(exers_scalu_issue), 32'd0);

        // Fill under stall.
        scalu_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            disp(5'h05, 7'(8'h40 + i), 6'(i), 1'b1, 32'(100 + i), 1'b1, 32'(200 + i));
            tick();
            check("fill_full", 32'(rs_full), (i == 3) ? 32'd1 : 32'd0);
        end
        // Dispatch while full must be ignored.
        disp(5'h06, 7'h50, 6'd9, 1'b1, 32'd1, 1'b1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            disp_valid = 1'b0;
            check("stall_issue", 32'(exers_scalu_issue), 32'd1);
            check("stall_robid", 32'(exers_robid), 32'h40);
            check("stall_op1", exers_op1, 32'd100);
        end
        scalu_stall = 1'b0;
        tick();
        check("drain_full", 32'(rs_full), 32'd0);
        check("drain1", 32'(exers_robid), 32'h41);
        tick();
        check("drain2", 32'(exers_robid), 32'h42);
        tick();
        check("drain3", 32'(exers_robid), 32'h43);
        check("drain3_op2", exers_op2, 32'd203);
        tick();
        check("drain_empty", 32'(exers_scalu_issue), 32'd0);

        // Flush with a same-cycle wakeup and dispatch.
        scalu_stall = 1'b1;
        disp(5'h07, 7'h60, 6'd1, 1'b1, 32'd1, 1'b1, 32'd2);
        tick();
        disp(5'h07, 7'h61, 6'd2, 1'b0, 32'h70, 1'b1, 32'd2);
        tick();
        disp(5'h07, 7'h62, 6'd3, 1'b1, 32'd1, 1'b1, 32'd2);
        tick();
        check("pre_flush_issue", 32'(exers_scalu_issue), 32'd1);
        disp(5'h07, 7'h63, 6'd4, 1'b1, 32'd1, 1'b1, 32'd2);
        wb_valid = 1'b1; wb_robid = 7'h70; wb_result = 32'h77;
        rob_flush = 1'b1;
        tick();
        rob_flush = 1'b0; wb_valid = 1'b0; disp_valid = 1'b0;
        check("flush_issue", 32'(exers_scalu_issue), 32'd0);
        check("flush_full", 32'(rs_full), 32'd0);
        scalu_stall = 1'b0;
        tick();
        tick();
        check("flush_stale", 32'(exers_scalu_issue), 32'd0);

        // Ordering: entry1 allocated before entry0, both ready.
        scalu_stall = 1'b1;
        disp(5'h08, 7'h01, 6'd1, 1'b1, 32'd11, 1'b1, 32'd0);
        tick();
        disp(5'h08, 7'h02, 6'd2, 1'b1, 32'd22, 1'b1, 32'd0);
        tick();
        disp_valid = 1'b0;
        scalu_stall = 1'b0;
        check("ord_first", 32'(exers_robid), 32'h01);
        tick();
        scalu_stall = 1'b1;
        disp(5'h08, 7'h03, 6'd3, 1'b1, 32'd33, 1'b1, 32'd0);
        tick();
        disp_valid = 1'b0;
`ifdef SCALU_RS_AGE_EN
        check("ord_sel_a", 32'(exers_robid), 32'h02);
`else
        check("ord_sel_a", 32'(exers_robid), 32'h03);
`endif
        scalu_stall = 1'b0;
        tick();
`ifdef SCALU_RS_AGE_EN
        check("ord_sel_b", 32'(exers_robid), 32'h03);
`else
        check("ord_sel_b", 32'(exers_robid), 32'h02);
`endif
        tick();
        check("ord_empty", 32'(exers_scalu_issue), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scalu_rs.md
Name: scalu_rs

Overview:
- Reservation station for the single-cycle scalar ALU; sits between dispatch and the scalu stage and drives the exers_scalu_* issue interface.
- Buffers up to DEPTH decoded ALU ops and captures missing operands from the writeback broadcast.
- Issues one ready op per cycle to scalu.
- Flushed wholesale on rob_flush.

Parameters:
- DEPTH, 4, number of entries (2..16).
- IDXW, 2, index width; must equal clog2(DEPTH).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- disp_valid  input  1  dispatch request
- disp_op  input  5  ALU opcode
- disp_robid  input  7  ROB id of the op
- disp_rd  input  6  destination register
- disp_op1_rdy  input  1  op1 value valid; when 0, disp_op1[6:0] is the producer robid tag
- disp_op1  input  32  op1 value or tag
- disp_op2_rdy  input  1  as op1
- disp_op2  input  32  as op1
- rs_full  output  1  all entries valid; dispatcher must not assert disp_valid
- wb_valid  input  1  writeback broadcast valid
- wb_robid  input  7  broadcast producer tag
- wb_result  input  32  broadcast value
- exers_scalu_issue  output  1  an op is presented to scalu
- exers_scalu_op  output  5  issued opcode
- exers_robid  output  7  issued robid
- exers_rd  output  6  issued destination
- exers_op1  output  32  issued op1 value
- exers_op2  output  32  issued op2 value
- scalu_stall  input  1  scalu cannot accept this cycle
- rob_flush  input  1  discard all entries

Behaviour:
- Reset is rst: synchronous, active-high, on clk.
- Per entry: valid, op, robid, rd, op1/op2 (32), r1/r2 ready bits.
- rst or rob_flush clears all valid bits at the next edge. rob_flush has priority over same-cycle dispatch and wakeup.
- After reset: rs_full=0 and exers_scalu_issue=0. Payload outputs are don't-care when issue=0; they are driven 0 when no entry is ready.
- Allocate: when disp_valid & ~rs_full, write the lowest-index free entry at the edge.
- disp_valid while rs_full is illegal; the block ignores it (no entry is written).
- rs_full is a pure function of registered valid bits. A slot freed by issue becomes usable next cycle, not the same cycle.
- Wakeup: for each valid entry with r1=0 and op1[6:0]==wb_robid while wb_valid, latch op1<=wb_result and set r1 at the edge. op2 uses the same rule.
- Dispatch-cycle capture: if a dispatched operand is not ready and its tag matches a same-cycle broadcast, store wb_result with ready=1.
- Ready = valid & r1 & r2, from registered state only. An entry woken at edge N is eligible in cycle N+1.
- Select: lowest-index ready entry, unless the optional feature is enabled.
- exers_scalu_issue = any ready entry. It is combinational from registers and independent of scalu_stall.
- Payload outputs are muxed from the selected entry.
- Issue handshake: the selected entry is freed at the edge iff exers_scalu_issue & ~scalu_stall.
- While scalu_stall=1, the selection must not change unless a different entry becomes ready at a lower index; scalu samples only when unstalled, so this is legal.
- Simultaneous alloc + free of different entries in one cycle is allowed.
- A wakeup of the entry being issued that cycle has no effect; that entry is already ready.
- Reset or flush mid-stall: all entries are dropped and issue deasserts next cycle.

Optional Feature:
- Macro: SCALU_RS_AGE_EN.
- When defined: keep a DEPTH x DEPTH age matrix. On alloc, set the new entry older-than bits to 0 and all others' bits for it to 1. Select the ready entry with no older ready entry, i.e. oldest-first.
- When undefined: no age matrix; lowest-index-first select.
- Allocation, wakeup, flush and handshake are identical in both builds.

Test Plan:
- Ready dispatch: disp op=5'h02, robid=7'h10, rd=6'd3, op1=32'd7, op2=32'd9, both rdy. Next cycle: issue=1 with those values. With scalu_stall=0 the entry frees; issue=0 the following cycle.
- Wakeup: dispatch robid=7'h11 with op1 tag 7'h10 unready. Two cycles later pulse wb_valid, wb_robid=7'h10, wb_result=32'hDEAD_BEEF. Issue asserts the cycle after, with exers_op1=32'hDEAD_BEEF.
- Same-cycle capture: dispatch op2 tag 7'h20 unready while wb_valid, robid 7'h20, result 32'h55. Issue next cycle with op2=32'h55.
- Full/stall: hold scalu_stall=1 and dispatch DEPTH ready ops. rs_full=1 after the 4th. The payload held stable for 3 cycles. Release the stall: one op issues per cycle, rs_full drops the cycle after the first free.
- Flush: with 3 entries valid, one woken that same cycle, assert rob_flush. Next cycle: issue=0, rs_full=0, and no stale entry issues afterwards.
- Ordering: same state in both builds, with entry1 filled before entry0 and both ready.
  - With SCALU_RS_AGE_EN: entry1 issues first.
  - Without SCALU_RS_AGE_EN: entry0 issues first.
